regfile_mp_sb: RTL and testbench

- Parametrised successor to the core's 32x32 register file.
- Adds configurable width, depth and read-port count, and two prioritised write ports with byte enables.
- Adds write-to-read bypass and a per-register busy scoreboard, so the decode stage can detect pending long-latency writes (loads, mul/div).
- Sits between decode (read ports, issue) and writeback (write port 0 = main pipeline, write port 1 = late/long-latency unit).

---
 rtl/core_pkg.sv | 13 +
 rtl/regfile_byte_merge.sv | 31 +++
 rtl/regfile_mp_sb.sv | 137 +++++++++++++
 tb/tb_regfile_mp_sb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared register-file constants and helpers.
// Imported by the register file and its byte-merge helper.
package core_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/regfile_byte_merge.sv
// Per-byte priority merge: port 0 over port 1 over stored data.
// Used for the write path and for each read bypass.
module regfile_byte_merge
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  p0_en,
  input  logic [DATA_W/8-1:0]   p0_be,
  input  logic [DATA_W-1:0]     p0_data,
  input  logic                  p1_en,
  input  logic [DATA_W/8-1:0]   p1_be,
  input  logic [DATA_W-1:0]     p1_data,
  input  logic [DATA_W-1:0]     st_data,
  output logic [DATA_W-1:0]     out_data
);

  localparam int BE_W = be_w(DATA_W);

  always_comb begin
    out_data = st_data;
    for (int b = 0; b < BE_W; b++) begin
      if (p0_en && p0_be[b]) begin
        out_data[8*b +: 8] = p0_data[8*b +: 8];
      end else if (p1_en && p1_be[b]) begin
        out_data[8*b +: 8] = p1_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with byte-enable writes,
// write-to-read bypass and a busy scoreboard.
module regfile_mp_sb
  import core_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W/8-1:0]      wr0_be,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W/8-1:0]      wr1_be,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     wr1_clr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = be_w(DATA_W);
  localparam logic [ADDR_W-1:0] RZ =
    ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [ADDR_W-1:0] wa;
  logic              wp1_same;
  logic              wa_ok;
  logic              w1_sep;
  logic [DATA_W-1:0] wa_st;
  logic [DATA_W-1:0] wa_d;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == RZ);
  endfunction

  // One merge covers port 0 and any port-1 hit on the
  // same address; a port-1 write elsewhere goes direct.
  assign wa       = wr0_en ? wr0_addr : wr1_addr;
  assign wp1_same = wr1_en && (wr1_addr == wa);
  assign wa_st    = mem_q[wa];
  assign wa_ok    = (wr0_en || wr1_en) && !is_zero(wa);
  assign w1_sep   = wr1_en && !wp1_same
                 && !is_zero(wr1_addr);

  regfile_byte_merge #(
    .DATA_W(DATA_W)
  ) u_wr_merge (
    .p0_en   (wr0_en),
    .p0_be   (wr0_be),
    .p0_data (wr0_data),
    .p1_en   (wp1_same),
    .p1_be   (wr1_be),
    .p1_data (wr1_data),
    .st_data (wa_st),
    .out_data(wa_d)
  );

  // A new producer supersedes a completing one.
  always_comb begin
    busy_d = busy_q;
    if (wr1_en && wr1_clr) busy_d[wr1_addr] = 1'b0;
    if (iss_en)            busy_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0)     busy_d[RZ]       = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wa_ok) mem_q[wa] <= wa_d;
      if (w1_sep) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wr1_be[b]) begin
            mem_q[wr1_addr][8*b +: 8] <=
              wr1_data[8*b +: 8];
          end
        end
      end
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              h0;
    logic              h1;
    logic [DATA_W-1:0] st;
    logic [DATA_W-1:0] byp;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    assign st = mem_q[ra];
    assign h0 = (BYPASS != 0) && wr0_en
             && (wr0_addr == ra);
    assign h1 = (BYPASS != 0) && wr1_en
             && (wr1_addr == ra);

    regfile_byte_merge #(
      .DATA_W(DATA_W)
    ) u_rd_merge (
      .p0_en   (h0),
      .p0_be   (wr0_be),
      .p0_data (wr0_data),
      .p1_en   (h1),
      .p1_be   (wr1_be),
      .p1_data (wr1_data),
      .st_data (st),
      .out_data(byp)
    );

    assign rd_data[k*DATA_W +: DATA_W] =
      (!rst_n || is_zero(ra)) ? '0 : byp;
    assign rd_busy[k] = rst_n && busy_q[ra];
  end

  assign busy_any = rst_n && (|busy_q);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb; a BYPASS=0 twin
// shares the inputs to check write visibility timing.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic        busy_any, nb_busy_any;
  logic        wr0_en, wr1_en, wr1_clr, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [3:0]  wr0_be, wr1_be;
  logic [31:0] wr0_data, wr1_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_be(wr0_be), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_be(wr1_be), .wr1_data(wr1_data),
    .wr1_clr(wr1_clr),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_any(busy_any)
  );

  regfile_mp_sb #(.BYPASS(0)) nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .rd_busy(nb_rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_be(wr0_be), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_be(wr1_be), .wr1_data(wr1_data),
    .wr1_clr(wr1_clr),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_any(nb_busy_any)
  );

  wire [31:0] rd0    = rd_data[31:0];
  wire [31:0] rd1    = rd_data[63:32];
  wire [31:0] nb_rd1 = nb_rd_data[63:32];

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_be = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_be = 0; wr1_data = 0;
    wr1_clr = 0; iss_en = 0; iss_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w0(input logic [4:0] a,
                    input logic [3:0] be,
                    input logic [31:0] d);
    wr0_en = 1; wr0_addr = a; wr0_be = be; wr0_data = d;
  endtask

  task automatic w1(input logic [4:0] a,
                    input logic [3:0] be,
                    input logic [31:0] d);
    wr1_en = 1; wr1_addr = a; wr1_be = be; wr1_data = d;
  endtask

  task automatic rd(input logic [4:0] a0,
                    input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    w0(5'd5, 4'hF, 32'hDEADBEEF);
    iss_en = 1; iss_addr = 5'd4;
    tick(); idle(); rd(5'd5, 5'd4);
    checks++;
    if (rd0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_pre_r5 got %h exp %h",
               rd0, 32'hDEADBEEF);
    end
    checks++;
    if (busy_any !== 1'b1 || rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy got %b/%b exp 1/1",
               busy_any, rd_busy[1]);
    end
    rst_n = 0;
    w0(5'd6, 4'hF, 32'h12345678);
    iss_en = 1; iss_addr = 5'd6;
    rd(5'd5, 5'd6);
    checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00
        || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL rst_low got %h %b %b exp 0 0 0",
               rd_data, rd_busy, busy_any);
    end
    tick(); rst_n = 1; idle(); rd(5'd5, 5'd6);
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
      errors++;
      $display("FAIL rst_post_data got %h %h exp 0 0",
               rd0, rd1);
    end
    checks++;
    if (busy_any !== 1'b0) begin
      errors++;
      $display("FAIL rst_post_busy got %b exp 0",
               busy_any);
    end
  endtask

  task automatic test_byte_en();
    w0(5'd3, 4'hF, 32'h11223344);
    tick(); idle();
    w0(5'd3, 4'b0101, 32'hAABBCCDD);
    tick(); idle(); rd(5'd3, 5'd0);
    checks++;
    if (rd0 !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_wr0 got %h exp %h",
               rd0, 32'h11BB33DD);
    end
    w1(5'd3, 4'b1000, 32'h99000000);
    tick(); idle(); rd(5'd3, 5'd0);
    checks++;
    if (rd0 !== 32'h99BB33DD) begin
      errors++;
      $display("FAIL be_wr1 got %h exp %h",
               rd0, 32'h99BB33DD);
    end
  endtask

  task automatic test_collision();
    w0(5'd7, 4'b0011, 32'h0000AAAA);
    w1(5'd7, 4'b1111, 32'h55555555);
    tick(); idle(); rd(5'd7, 5'd0);
    checks++;
    if (rd0 !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL coll_merge got %h exp %h",
               rd0, 32'h5555AAAA);
    end
    w0(5'd7, 4'b0001, 32'h000000EE);
    w1(5'd7, 4'b0001, 32'h000000FF);
    tick(); idle(); rd(5'd7, 5'd0);
    checks++;
    if (rd0 !== 32'h5555AAEE) begin
      errors++;
      $display("FAIL coll_prio got %h exp %h",
               rd0, 32'h5555AAEE);
    end
    w0(5'd8, 4'hF, 32'h01020304);
    w1(5'd10, 4'hF, 32'hA0B0C0D0);
    tick(); idle(); rd(5'd8, 5'd10);
    checks++;
    if (rd0 !== 32'h01020304 || rd1 !== 32'hA0B0C0D0) begin
      errors++;
      $display("FAIL dual_addr got %h %h exp %h %h",
               rd0, rd1, 32'h01020304, 32'hA0B0C0D0);
    end
  endtask

  task automatic test_bypass();
    w0(5'd9, 4'hF, 32'h12345678);
    tick(); idle();
    w1(5'd9, 4'hF, 32'hCAFEF00D);
    rd(5'd0, 5'd9);
    checks++;
    if (rd1 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL byp_same got %h exp %h",
               rd1, 32'hCAFEF00D);
    end
    checks++;
    if (nb_rd1 !== 32'h12345678) begin
      errors++;
      $display("FAIL nobyp_old got %h exp %h",
               nb_rd1, 32'h12345678);
    end
    tick(); idle(); rd(5'd0, 5'd9);
    checks++;
    if (nb_rd1 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL nobyp_next got %h exp %h",
               nb_rd1, 32'hCAFEF00D);
    end
    w0(5'd9, 4'b0001, 32'h000000AA);
    w1(5'd9, 4'b0011, 32'h0000BBBB);
    rd(5'd9, 5'd0);
    checks++;
    if (rd0 !== 32'hCAFEBBAA) begin
      errors++;
      $display("FAIL byp_merge got %h exp %h",
               rd0, 32'hCAFEBBAA);
    end
    tick(); idle();
  endtask

  task automatic test_zero();
    w0(5'd0, 4'hF, 32'hFFFFFFFF);
    iss_en = 1; iss_addr = 5'd0;
    rd(5'd0, 5'd0);
    checks++;
    if (rd0 !== 32'h0) begin
      errors++;
      $display("FAIL zero_byp got %h exp 0", rd0);
    end
    tick(); idle(); rd(5'd0, 5'd0);
    checks++;
    if (rd0 !== 32'h0 || rd_busy !== 2'b00
        || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg got %h %b %b exp 0 00 0",
               rd0, rd_busy, busy_any);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_addr = 5'd12;
    tick(); idle(); rd(5'd0, 5'd12);
    checks++;
    if (rd_busy[1] !== 1'b1 || busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_set got %b %b exp 1 1",
               rd_busy[1], busy_any);
    end
    tick(); tick();
    w1(5'd12, 4'hF, 32'h0000C0DE); wr1_clr = 1;
    iss_en = 1; iss_addr = 5'd12;
    rd(5'd0, 5'd12);
    checks++;
    if (rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL sb_pre_edge got %b exp 1",
               rd_busy[1]);
    end
    tick(); idle(); rd(5'd0, 5'd12);
    checks++;
    if (rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins got %b exp 1",
               rd_busy[1]);
    end
    w1(5'd12, 4'hF, 32'h0000BEEF); wr1_clr = 1;
    rd(5'd0, 5'd12);
    checks++;
    if (rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL sb_same_cyc_clr got %b exp 1",
               rd_busy[1]);
    end
    tick(); idle(); rd(5'd12, 5'd12);
    checks++;
    if (rd_busy !== 2'b00 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear got %b %b exp 00 0",
               rd_busy, busy_any);
    end
    checks++;
    if (rd0 !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL sb_wr1_data got %h exp %h",
               rd0, 32'h0000BEEF);
    end
    iss_en = 1; iss_addr = 5'd13;
    tick(); idle();
    w0(5'd13, 4'hF, 32'h1);
    w1(5'd14, 4'hF, 32'h2); wr1_clr = 1;
    tick(); idle();
    w1(5'd13, 4'hF, 32'h3);
    tick(); idle(); rd(5'd13, 5'd14);
    checks++;
    if (rd_busy !== 2'b01 || busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_no_clr got %b %b exp 01 1",
               rd_busy, busy_any);
    end
    w1(5'd13, 4'hF, 32'h4); wr1_clr = 1;
    tick(); idle(); rd(5'd13, 5'd14);
    checks++;
    if (rd_busy !== 2'b00 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL sb_clr13 got %b %b exp 00 0",
               rd_busy, busy_any);
    end
  endtask

  initial begin
    rst_n = 0; rd_addr = '0; idle();
    tick(); tick();
    rst_n = 1;
    test_reset();
    test_byte_en();
    test_collision();
    test_bypass();
    test_zero();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
